// File: rtl/alu_pkg.sv
// Shared types for the sequential execute ALU: opcode encoding, handshake FSM
// states and the classification of iterative (multi-cycle) operations.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide engine: one bit per cycle, XLEN steps.
// Shift-add multiply over a 2*XLEN product; restoring divide on quo/rem.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              running;
  logic [CW-1:0]     cnt;
  alu_op_e           op_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   rem, rem_n, quo, quo_n;
  logic [XLEN:0]     psum, shifted;
  logic              ge;

  // Both datapaths step every running cycle; op_q only selects which one is read.
  always_comb begin
    psum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    prod_n  = {psum, prod[XLEN-1:1]};
    shifted = {rem, quo[XLEN-1]};
    ge      = shifted >= {1'b0, opnd};
    rem_n   = ge ? shifted[XLEN-1:0] - opnd : shifted[XLEN-1:0];
    quo_n   = {quo[XLEN-2:0], ge};
    done    = running && (cnt == CW'(XLEN-1));
    case (op_q)
      OP_MUL:   result = prod_n[XLEN-1:0];
      OP_MULHU: result = prod_n[2*XLEN-1:XLEN];
      OP_DIVU:  result = quo_n;
      OP_REMU:  result = rem_n;
      default:  result = '0;
    endcase
  end

  // Divide by zero needs no special case: every step subtracts zero, so the
  // quotient fills with ones and the remainder ends up equal to the dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      op_q    <= OP_ADD;
      opnd    <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_q    <= op;
      opnd    <= (op inside {OP_DIVU, OP_REMU}) ? b : a;
      prod    <= {{XLEN{1'b0}}, b};
      rem     <= '0;
      quo     <= a;
    end else if (running) begin
      cnt  <= cnt + CW'(1);
      prod <= prod_n;
      rem  <= rem_n;
      quo  <= quo_n;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready handshake and a registered result.
// Single-cycle ops finish in one cycle; MUL/DIV-class ops iterate for XLEN cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ain,
  input  logic [XLEN-1:0] bin,
  input  logic [3:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state, state_n;
  alu_op_e         op;
  logic [SHW-1:0]  shamt;
  logic            accept, go_multi;
  logic            load_fast, load_md, md_start, md_done;
  logic [XLEN-1:0] fast_res, md_res, res_d;

  assign op       = alu_op_e'(alu_op);
  assign shamt    = bin[SHW-1:0];
  assign go_multi = EN_MULDIV && is_multicycle(op);

  // Single-cycle datapath; MUL-class ops land here only when muldiv is absent.
  always_comb begin
    fast_res = '0;
    case (op)
      OP_ADD:  fast_res = ain + bin;
      OP_SUB:  fast_res = ain - bin;
      OP_AND:  fast_res = ain & bin;
      OP_OR:   fast_res = ain | bin;
      OP_XOR:  fast_res = ain ^ bin;
      OP_SLL:  fast_res = ain << shamt;
      OP_SRL:  fast_res = ain >> shamt;
      OP_SRA:  fast_res = $signed(ain) >>> shamt;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(ain) < $signed(bin)};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, ain < bin};
      default: fast_res = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load_fast = 1'b0;
    load_md   = 1'b0;
    md_start  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      CALC: begin
        busy = 1'b1;
        if (md_done) begin
          state_n = DONE;
          load_md = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new request in DONE overrides the return to IDLE for back-to-back issue.
    accept = in_valid && in_ready;
    if (accept) begin
      if (go_multi) begin
        state_n  = CALC;
        md_start = 1'b1;
      end else begin
        state_n   = DONE;
        load_fast = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign res_d = load_md ? md_res : fast_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      zero_flag  <= 1'b1;
    end else if (load_fast || load_md) begin
      alu_result <= res_d;
      zero_flag  <= (res_d == '0);
    end
  end

  generate
    if (EN_MULDIV) begin : g_md
      alu_muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op),
        .a      (ain),
        .b      (bin),
        .done   (md_done),
        .result (md_res)
      );
    end else begin : g_nomd
      // CALC is unreachable without muldiv; md_start is constant 0 here.
      assign md_done = md_start;
      assign md_res  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a
// negedge monitor checks value, zero flag and first-valid cycle of each result.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero_flag, busy;
  logic [31:0] ain, bin, alu_result;
  logic [3:0]  alu_op;

  logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_zero, v8_busy;
  logic [7:0] v8_ain, v8_bin, v8_result;
  logic [3:0] v8_op;

  typedef struct {
    logic [31:0] res;
    int          first;
    bit          seen;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .bin(bin), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .busy(busy)
  );

  alu_seq #(.XLEN(8), .EN_MULDIV(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .ain(v8_ain), .bin(v8_bin), .alu_op(v8_op), .out_valid(v8_out_valid),
    .out_ready(1'b1), .alu_result(v8_result), .zero_flag(v8_zero),
    .busy(v8_busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid cycle must show the head result (covers stability under
  // backpressure); latency is checked on the first valid cycle, zero flag on pop.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_out_valid: got result %0h, required no output", alu_result);
      end else begin
        if (!sb[0].seen) begin
          check({sb[0].name, "_latency"}, 64'(cyc), 64'(sb[0].first));
          sb[0].seen = 1'b1;
        end
        check(sb[0].name, 64'(alu_result), 64'(sb[0].res));
        if (out_ready) begin
          check({sb[0].name, "_zero"}, 64'(zero_flag), 64'(sb[0].res == 32'd0));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit track);
    int n = 0;
    in_valid = 1'b1;
    alu_op   = op;
    ain      = a;
    bin      = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_accept: got in_ready 0 after 200 cycles, required 1", nm);
    end
    if (track) sb.push_back('{exp, cyc + lat, 1'b0, nm});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check({nm, "_drain_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic t8(input string nm, input logic [3:0] op, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] exp);
    v8_in_valid = 1'b1;
    v8_op       = op;
    v8_ain      = a;
    v8_bin      = b;
    check({nm, "_in_ready"}, 64'(v8_in_ready), 64'd1);
    tick();
    v8_in_valid = 1'b0;
    check({nm, "_out_valid"}, 64'(v8_out_valid), 64'd1);
    check(nm, 64'(v8_result), 64'(exp));
    check({nm, "_zero"}, 64'(v8_zero), 64'(exp == 8'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    bit bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ain = '0; bin = '0; alu_op = '0;
    v8_in_valid = 1'b0; v8_ain = '0; v8_bin = '0; v8_op = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready",  64'(in_ready),   64'd1);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_result",    64'(alu_result), 64'd0);
    check("rst_zero",      64'(zero_flag),  64'd1);
    check("rst8_out_valid", 64'(v8_out_valid), 64'd0);

    // Single-cycle ops, issued back to back
    issue("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,  32'd0,          1, 1'b1);
    issue("sra",       4'b0111, 32'h8000_0000, 32'd4,  32'hF800_0000,  1, 1'b1);
    issue("slt",       4'b1000, 32'hFFFF_FFFF, 32'd1,  32'd1,          1, 1'b1);
    issue("sltu",      4'b1001, 32'hFFFF_FFFF, 32'd1,  32'd0,          1, 1'b1);
    issue("sub_neg",   4'b0001, 32'd5,         32'd7,  32'hFFFF_FFFE,  1, 1'b1);
    issue("and",       4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1'b1);
    issue("or",        4'b0011, 32'hF000_000F, 32'h0000_00F0, 32'hF000_00FF, 1, 1'b1);
    issue("xor",       4'b0100, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1, 1'b1);
    issue("sll31",     4'b0101, 32'd1,         32'd31, 32'h8000_0000,  1, 1'b1);
    issue("sll_wrapamt", 4'b0101, 32'd1,       32'd33, 32'd2,          1, 1'b1);
    issue("srl31",     4'b0110, 32'h8000_0000, 32'd31, 32'd1,          1, 1'b1);
    issue("rsv",       4'b1110, 32'd9,         32'd9,  32'd0,          1, 1'b1);
    drain("alu1");

    for (int i = 0; i < 4; i++) begin
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      issue("b2b_add", 4'b0000, 32'(i * 100), 32'd7, 32'(i * 100 + 7), 1, 1'b1);
    end
    drain("b2b");

    // Iterative ops
    issue("mul_lo", 4'b1010, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!busy || in_ready) bad = 1'b1;
      tick();
    end
    check("calc_busy_not_ready", 64'(bad), 64'd0);
    check("busy_after_calc", 64'(busy), 64'd0);
    drain("mul_lo");

    issue("mulhu",     4'b1011, 32'h0001_0000, 32'h0001_0000, 32'd1,         33, 1'b1);
    issue("mul_small", 4'b1010, 32'd7,         32'd6,         32'd42,        33, 1'b1);
    issue("mul_max",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33, 1'b1);
    issue("mulhu_max", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    issue("divu",      4'b1100, 32'd100,       32'd7,         32'd14,        33, 1'b1);
    issue("remu",      4'b1101, 32'd100,       32'd7,         32'd2,         33, 1'b1);
    issue("divu_by0",  4'b1100, 32'd12345,     32'd0,         32'hFFFF_FFFF, 33, 1'b1);
    issue("remu_by0",  4'b1101, 32'd5,         32'd0,         32'd5,         33, 1'b1);
    issue("add_after_md", 4'b0000, 32'd40,     32'd2,         32'd42,        1,  1'b1);
    drain("muldiv");

    // Backpressure: result held, inputs ignored while out_ready is low
    out_ready = 1'b0;
    issue("bp_add", 4'b0000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready || !out_valid) bad = 1'b1;
      ain = $urandom;
      bin = $urandom;
      tick();
    end
    check("bp_hold_handshake", 64'(bad), 64'd0);
    out_ready = 1'b1;
    drain("bp");

    // Reset in the middle of a divide aborts it
    issue("divu_abort", 4'b1100, 32'd100, 32'd7, 32'd0, 33, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("abort_out_valid", 64'(out_valid),  64'd0);
    check("abort_result",    64'(alu_result), 64'd0);
    check("abort_zero",      64'(zero_flag),  64'd1);
    check("abort_busy",      64'(busy),       64'd0);
    check("abort_in_ready",  64'(in_ready),   64'd1);
    repeat (40) tick();
    issue("add_post_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1, 1'b1);
    drain("post_rst");

    // XLEN=8, no muldiv instance
    t8("x8_mul",   4'b1010, 8'd3,   8'd5, 8'd0);
    t8("x8_add",   4'b0000, 8'hFF,  8'd2, 8'd1);
    t8("x8_sra",   4'b0111, 8'h80,  8'd9, 8'hC0);
    t8("x8_divu",  4'b1100, 8'd9,   8'd3, 8'd0);
    t8("x8_sltu",  4'b1001, 8'hFF,  8'd1, 8'd0);
    tick();
    check("x8_idle_out_valid", 64'(v8_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
